// File: rtl/mult_arbiter_pkg.sv
// rtl/mult_arbiter_pkg.sv - shared select encodings, lane count and lane-state enum for mult_arbiter
package mult_arbiter_pkg;

    localparam int NUM_LANES = 3;

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_L0   = 2'b01;
    localparam logic [1:0] SEL_L1   = 2'b10;
    localparam logic [1:0] SEL_L2   = 2'b11;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/mult_arbiter_mux.sv
// rtl/mult_arbiter_mux.sv - mult_mux: shared DATA_W x DATA_W unsigned multiplier with 2-bit operand select
module mult_mux
    import mult_arbiter_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]          sel,
    input  logic [DATA_W-1:0]   a0,
    input  logic [DATA_W-1:0]   k0,
    input  logic [DATA_W-1:0]   a1,
    input  logic [DATA_W-1:0]   k1,
    input  logic [DATA_W-1:0]   a2,
    input  logic [DATA_W-1:0]   k2,
    output logic [2*DATA_W-1:0] prod
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_k;

    always_comb begin
        op_a = '0;
        op_k = '0;
        case (sel)
            SEL_L0: begin op_a = a0; op_k = k0; end
            SEL_L1: begin op_a = a1; op_k = k1; end
            SEL_L2: begin op_a = a2; op_k = k2; end
            default: begin op_a = '0; op_k = '0; end
        endcase
    end

    assign prod = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_k};

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin share of one multiplier across three lanes; MULT_ARB_ACC_EN adds per-lane accumulation
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PROD_W = 2 * DATA_W,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req_valid,
    input  logic [2:0]        req_last,
    output logic [2:0]        req_ready,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] k0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] k1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] k2,
    output logic [2:0]        resp_valid,
    output logic [ACC_W-1:0]  resp_data,
    output logic              resp_ovf,
    output logic [1:0]        gnt_sel
);

    logic [1:0]        ptr;
    logic              gnt_any;
    logic [1:0]        gnt_lane;
    logic [2:0]        idx;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;

    // First valid lane at or after ptr wins; rst forces no grant.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_lane = 2'd0;
        idx      = 3'd0;
        for (int off = 0; off < NUM_LANES; off++) begin
            idx = {1'b0, ptr} + 3'(off);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (!gnt_any && !rst && req_valid[idx[1:0]]) begin
                gnt_any  = 1'b1;
                gnt_lane = idx[1:0];
            end
        end
    end

    assign req_ready = gnt_any ? (3'b001 << gnt_lane) : 3'b000;
    assign gnt_sel   = gnt_any ? (gnt_lane + 2'd1) : SEL_IDLE;

    always_ff @(posedge clk) begin
        if (rst)          ptr <= 2'd0;
        else if (gnt_any) ptr <= (gnt_lane == 2'd2) ? 2'd0 : gnt_lane + 2'd1;
    end

    mult_mux #(.DATA_W(DATA_W)) u_mult_mux (
        .sel  (gnt_sel),
        .a0   (a0),
        .k0   (k0),
        .a1   (a1),
        .k1   (k1),
        .a2   (a2),
        .k2   (k2),
        .prod (prod)
    );

    assign prod_ext = ACC_W'(prod);

`ifdef MULT_ARB_ACC_EN
    logic [ACC_W-1:0] acc   [NUM_LANES];
    acc_state_t       st    [NUM_LANES];
    logic             ovf_q [NUM_LANES];
    logic [ACC_W-1:0] acc_in;
    logic             ovf_in;
    logic [ACC_W:0]   sum;

    // An idle lane starts from zero so a lone last beat returns the bare product.
    always_comb begin
        acc_in = (st[gnt_lane] == ACC_RUN) ? acc[gnt_lane] : '0;
        ovf_in = (st[gnt_lane] == ACC_RUN) && ovf_q[gnt_lane];
        sum    = {1'b0, acc_in} + {1'b0, prod_ext};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 3'b000;
            resp_data  <= '0;
            resp_ovf   <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                acc[i]   <= '0;
                st[i]    <= ACC_IDLE;
                ovf_q[i] <= 1'b0;
            end
        end else begin
            resp_valid <= 3'b000;
            if (gnt_any) begin
                if (req_last[gnt_lane]) begin
                    resp_valid      <= 3'b001 << gnt_lane;
                    resp_data       <= sum[ACC_W-1:0];
                    resp_ovf        <= ovf_in | sum[ACC_W];
                    acc[gnt_lane]   <= '0;
                    st[gnt_lane]    <= ACC_IDLE;
                    ovf_q[gnt_lane] <= 1'b0;
                end else begin
                    acc[gnt_lane]   <= sum[ACC_W-1:0];
                    st[gnt_lane]    <= ACC_RUN;
                    ovf_q[gnt_lane] <= ovf_in | sum[ACC_W];
                end
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 3'b000;
            resp_data  <= '0;
        end else begin
            resp_valid <= 3'b000;
            if (gnt_any) begin
                resp_valid <= 3'b001 << gnt_lane;
                resp_data  <= prod_ext;
            end
        end
    end

    assign resp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - scoreboard bench for mult_arbiter (both MULT_ARB_ACC_EN builds)
module tb_mult_arbiter;

    localparam int  DATA_W = 8;
    localparam int  ACC_W  = 16;
    localparam longint MASK = (64'd1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req_valid, req_last, req_ready, resp_valid;
    logic [ACC_W-1:0] resp_data;
    logic             resp_ovf;
    logic [1:0]       gnt_sel;
    logic [DATA_W-1:0] opa [3];
    logic [DATA_W-1:0] opk [3];

    typedef struct {
        int     lane;
        longint data;
        bit     ovf;
    } exp_t;

    exp_t   q[$];
    int     tests = 0;
    int     fails = 0;
    int     mptr = 0;
    int     last_gnt = -1;
    bit     post_rst = 0;
    longint macc [3];
    bit     mrun [3];
    bit     movf [3];

    always #5 clk = ~clk;

    mult_arbiter #(.DATA_W(DATA_W), .PROD_W(2*DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
        .a0(opa[0]), .k0(opk[0]), .a1(opa[1]), .k1(opk[1]), .a2(opa[2]), .k2(opk[2]),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ovf(resp_ovf),
        .gnt_sel(gnt_sel)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        mptr = 0;
        for (int i = 0; i < 3; i++) begin
            macc[i] = 0; mrun[i] = 0; movf[i] = 0;
        end
    endtask

    task automatic step(input logic [2:0] v, input logic [2:0] l);
        int     g;
        longint p, s;
        bit     c;
        exp_t   e;
        req_valid = v;
        req_last  = l;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("resp_valid", resp_valid, 64'(3'b001 << e.lane));
            chk("resp_data", resp_data, e.data);
            chk("resp_ovf", resp_ovf, e.ovf);
        end else begin
            chk("resp_idle", resp_valid, 0);
        end
        if (post_rst) begin
            chk("rst_data", resp_data, 0);
            chk("rst_ovf", resp_ovf, 0);
            post_rst = 0;
        end
        last_gnt = -1;
        if (rst) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_gnt_sel", gnt_sel, 0);
            model_clear();
            post_rst = 1;
        end else begin
            g = -1;
            for (int off = 0; off < 3; off++)
                if (g < 0 && v[(mptr + off) % 3]) g = (mptr + off) % 3;
            chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
            chk("gnt_sel", gnt_sel, (g < 0) ? 0 : g + 1);
            if (g >= 0) begin
                p = longint'(opa[g]) * longint'(opk[g]);
`ifdef MULT_ARB_ACC_EN
                s = (mrun[g] ? macc[g] : 0) + p;
                c = (s > MASK);
                if (l[g]) begin
                    e.lane = g; e.data = s & MASK; e.ovf = (mrun[g] && movf[g]) || c;
                    q.push_back(e);
                    macc[g] = 0; mrun[g] = 0; movf[g] = 0;
                end else begin
                    movf[g] = (mrun[g] && movf[g]) || c;
                    macc[g] = s & MASK; mrun[g] = 1;
                end
`else
                s = p; c = 0;
                e.lane = g; e.data = p & MASK; e.ovf = c;
                q.push_back(e);
`endif
                mptr = (g + 1) % 3;
                last_gnt = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int lane, input int a, input int k);
        opa[lane] = DATA_W'(a);
        opk[lane] = DATA_W'(k);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 3'b000;
        req_last  = 3'b000;
        for (int i = 0; i < 3; i++) set_op(i, 0, 0);
        model_clear();

        // Reset with all lanes requesting: nothing granted, outputs cleared.
        step(3'b111, 3'b000);
        step(3'b111, 3'b000);
        rst = 1'b0;

        // Lane 1 alone: 3*5 = 15, ptr moves to 2.
        set_op(1, 3, 5);
        step(3'b010, 3'b000);
        step(3'b000, 3'b000);

        // Lane 2 alone brings ptr to 0, then full rotation with fresh operands.
        set_op(2, 7, 9);
        step(3'b100, 3'b000);
        for (int i = 0; i < 3; i++) set_op(i, $urandom_range(0, 255), $urandom_range(0, 255));
        for (int n = 0; n < 6; n++) begin
            step(3'b111, 3'b000);
            if (last_gnt >= 0) set_op(last_gnt, $urandom_range(0, 255), $urandom_range(0, 255));
        end
        step(3'b000, 3'b000);

        // Lane 0 waits while lane 1 holds the grant, then goes next.
        set_op(0, 11, 13);
        step(3'b001, 3'b000);
        set_op(0, 200, 250);
        set_op(1, 255, 255);
        step(3'b011, 3'b000);
        step(3'b001, 3'b000);
        step(3'b000, 3'b000);

        // Lane 0 group: 2*3 + 4*5 + 1*1 = 27.
        set_op(0, 2, 3);  step(3'b001, 3'b000);
        set_op(0, 4, 5);  step(3'b001, 3'b000);
        set_op(0, 1, 1);  step(3'b001, 3'b001);
        step(3'b000, 3'b000);

        // Lane 2 group wraps the 16-bit accumulator: 64514 with overflow.
        set_op(2, 255, 255);
        step(3'b100, 3'b000);
        step(3'b100, 3'b100);
        step(3'b000, 3'b000);

        // Lane 1 group interrupted by reset; next group restarts at zero: 42.
        set_op(1, 2, 2);  step(3'b010, 3'b000);
        set_op(1, 3, 3);  step(3'b010, 3'b000);
        rst = 1'b1;
        step(3'b010, 3'b000);
        rst = 1'b0;
        set_op(1, 6, 7);  step(3'b010, 3'b010);
        step(3'b000, 3'b000);

        // Lone last beats on every lane return bare products.
        set_op(0, 17, 3);
        set_op(1, 128, 2);
        set_op(2, 255, 1);
        step(3'b111, 3'b111);
        step(3'b111, 3'b111);
        step(3'b111, 3'b111);
        step(3'b000, 3'b000);
        step(3'b000, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler that shares one 8x8 unsigned multiplier among three requester lanes (three convolution channels of the CNN datapath). Each cycle it grants at most one valid lane, steers the shared multiplier's 2-bit select to that lane's operand pair, and registers the product. Optionally it accumulates products per lane into multiply-accumulate results. It sits between the convolution window generators and the adder/activation stage.

## Interface
- DATA_W, 8, operand width (multiplier is DATA_W x DATA_W)
- PROD_W, 16, product width; fixed at 2*DATA_W
- ACC_W, 20, result/accumulator width; must be >= PROD_W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  3  per-lane operand-pair valid
- req_last  in  3  per-lane "final beat of accumulation group"; qualified by valid
- req_ready  out  3  per-lane grant; one-hot or zero
- a0,k0 / a1,k1 / a2,k2  in  DATA_W each  lane operands; must be held while valid and not ready
- resp_valid  out  3  one-hot response strobe, lane-indexed
- resp_data  out  ACC_W  product or accumulated result
- resp_ovf  out  1  accumulator wrapped during the reported group (0 when accumulation compiled out)
- gnt_sel  out  2  select value driven to the multiplier; 00 = idle, 01/10/11 = lane 0/1/2

## Operation
- Arbitration is combinational from req_valid and a 2-bit round-robin pointer ptr (values 0..2).
  - Grant goes to the first valid lane at or after ptr, checking ptr, ptr+1, ptr+2 mod 3.
  - req_ready[i] is high only for the granted lane. req_ready may depend on req_valid.
- Handshake: a beat transfers in the cycle where req_valid[i] and req_ready[i] are both high.
  - After a grant to lane i, ptr becomes (i+1) mod 3.
  - With no grant, ptr holds.
  - Lanes with valid low are skipped with no lost cycle.
- gnt_sel = granted lane + 1; it is 00 when nothing is granted.
  - The product register loads only on a granted cycle, so the multiplier's output when gnt_sel = 00 is never consumed.
- Arithmetic is unsigned. The product is zero-extended to ACC_W.
- Responses cannot be backpressured. At most one resp_valid bit is high per cycle.

## Timing
- Reset values:
  - ptr = 0
  - resp_valid = 000
  - resp_data = 0
  - resp_ovf = 0
  - all accumulators 0, all lane states ACC_IDLE
- req_ready and gnt_sel are combinational. During rst they are held at 0.
- Latency is 1: a beat accepted in cycle T produces resp_valid in T+1 (only on the last beat when accumulating).
- Throughput is one multiply per cycle, aggregate. With all three lanes continuously valid, grants rotate 0,1,2,0,...
- A rst asserted mid-group discards partial accumulations. No response is emitted for beats accepted in the reset cycle.

## Configuration
- Macro: MULT_ARB_ACC_EN.
- Defined: each lane has an ACC_W accumulator and a lane state, ACC_IDLE or ACC_RUN.
  - ACC_IDLE: an accepted beat without last loads acc = product and moves the lane to ACC_RUN.
  - ACC_RUN: an accepted beat without last sets acc += product.
  - Last beat, in either state: resp_data = acc_in + product, where acc_in is 0 in ACC_IDLE. The accumulator clears and the lane returns to ACC_IDLE.
  - resp_ovf is high if any carry out of ACC_W occurred within the group. The sum wraps modulo 2^ACC_W.
  - A single beat with last in ACC_IDLE returns the bare product.
- Undefined: there are no accumulators and req_last is ignored.
  - Every accepted beat produces resp_valid in T+1, with resp_data = zero-extended product.
  - resp_ovf is tied to 0.

## Structure
- Shared package holds:
  - the select encodings SEL_IDLE = 2'b00, SEL_L0 = 2'b01, SEL_L1 = 2'b10, SEL_L2 = 2'b11
  - NUM_LANES = 3
  - the lane-state enum (ACC_IDLE, ACC_RUN)
- The block instantiates the existing mult_mux as its single sub-module. sel is driven by gnt_sel and the six operand inputs pass straight through.
- Arbitration, the pointer and the accumulators are local logic.

## Test plan
- Reset, then lane 1 only: a1=3, k1=5, valid for one cycle (accumulation compiled out) -> req_ready=010, gnt_sel=10, next cycle resp_valid=010, resp_data=15, ptr=2.
- All lanes valid for 6 cycles, pointer at 0 -> grant order 0,1,2,0,1,2; gnt_sel 01,10,11,01,10,11; one response per cycle.
- MULT_ARB_ACC_EN, lane 0 beats (2,3), (4,5), (1,1 with last) -> a single resp_valid=001 with resp_data=27, resp_ovf=0, one cycle after the last beat.
- MULT_ARB_ACC_EN, ACC_W=16, lane 2 sends 2 beats of 255x255 with last on beat 2 -> resp_data=(2*65025) mod 65536=64514, resp_ovf=1.
- Lane 0 holds valid with operands while lane 1 is granted -> lane 0 operands unchanged, granted the following cycle; no response for lane 0 until then.
- MULT_ARB_ACC_EN, lane 1 mid-group (2 beats accepted), rst for 1 cycle, then a beat (6,7) with last -> resp_data=42 and all outputs at reset values during rst.
